fp_alu_scheduler: RTL and testbench
===================================

// Module: fp_alu_scheduler
// PURPOSE
//  Round-robin scheduler that shares one combinational IEEE-754 single-precision ALU
//  (ports a, b, sel -> out) between N_REQ requesters. Operands and op select are held
//  stable in registers for ALU_LAT cycles, giving the ALU a multicycle path. The result
//  is then registered and returned to the winning requester over a valid/ready response.
//  Sits between the requester clients and the single ALU instance.
// PARAMETERS
//  N_REQ    4   number of requesters (>=2); IDW = $clog2(N_REQ)
//  WIDTH    32  operand/result width (IEEE-754 single)
//  SEL_W    3   ALU op-select width; passed through unmodified
//  ALU_LAT  2   cycles operands are held before out is sampled (>=1)
// PORTS
//  clk        in   1            rising-edge clock, single domain
//  rst        in   1            synchronous, active-high reset
//  req_valid  in   N_REQ        per-requester request valid
//  req_ready  out  N_REQ        one-hot grant; at most one bit high
//  req_a      in   N_REQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH]
//  req_b      in   N_REQ*WIDTH  operand B, same packing
//  req_sel    in   N_REQ*SEL_W  op select, requester i at [i*SEL_W +: SEL_W]
//  alu_a      out  WIDTH        registered operand A to ALU
//  alu_b      out  WIDTH        registered operand B to ALU
//  alu_sel    out  SEL_W        registered op select to ALU
//  alu_out    in   WIDTH        ALU combinational result
//  rsp_valid  out  N_REQ        one-hot response valid to the owning requester
//  rsp_ready  in   N_REQ        per-requester response ready
//  rsp_data   out  WIDTH        registered result, shared by all requesters
//  busy       out  1            high in any state other than IDLE
//  grant_id   out  IDW          index of the current or last owner
// BEHAVIOUR
//  Reset: state=IDLE, rr_ptr=0, cnt=0, alu_a/alu_b/alu_sel=0, rsp_data=0,
//   rsp_valid=0, req_ready=0, busy=0, grant_id=0. Reset wins over all events at the same
//   edge, including mid-EXEC and mid-RESP. An in-flight op is dropped with no response.
//  FSM IDLE -> EXEC -> RESP -> IDLE.
//  IDLE: winner = first i with req_valid[i], searching from rr_ptr upward with wrap
//   N_REQ-1 -> 0. req_ready[winner] is asserted combinationally in IDLE only.
//   At the edge where req_valid[winner] is high: latch a/b/sel into alu_*, set
//   grant_id=winner, cnt=ALU_LAT-1, go to EXEC. If no req_valid is high, stay in IDLE.
//  EXEC: alu_* are held constant. If cnt!=0, decrement cnt. If cnt==0, rsp_data<=alu_out
//   and go to RESP. The sample occurs at the ALU_LAT-th edge after the accept edge.
//  RESP: rsp_valid[grant_id]=1 and rsp_data is stable until rsp_ready[grant_id] is high
//   at an edge. At that edge: go to IDLE and set rr_ptr = (grant_id+1) mod N_REQ.
//   rsp_ready bits of other requesters are ignored.
//  req_ready stays 0 outside IDLE. Requests arriving while busy wait; none is lost or
//   reordered per requester. Minimum op period is ALU_LAT+2 cycles.
//  A requester deasserting req_valid before its grant is legal. It simply loses the
//   arbitration in that cycle.
//  alu_sel is forwarded bit-exact. No opcode decoding or IEEE exception handling here.
// TESTING
//  Stub ALU for scenarios 1-4 and 6: alu_out = alu_a + alu_b (integer), ALU_LAT=2.
//  1 rst high 3 cycles, then idle -> all outputs 0.
//    req0 a=5 b=7 sel=3'b010 accepted at edge E0 -> rsp_valid=4'b0001 after E2,
//    rsp_data=12; alu_a/b/sel stable E0..E2.
//  2 req0..req3 held valid continuously, rsp_ready=4'hF -> grants in order 0,1,2,3,0.
//    One op per 4 cycles; req_ready never has more than one bit set.
//  3 rsp_ready[1]=0 for 10 cycles while req1 response is pending -> rsp_valid=4'b0010 and
//    rsp_data held; req_ready=0; busy=1 throughout; finishes on the first ready edge.
//  4 rst pulsed 1 cycle while in EXEC -> next cycle IDLE, rsp_valid=0, rr_ptr=0.
//    No response is issued for the dropped op.
//  5 Real ALU instance: sel=3'b101, a=32'h41400000, b=32'h40800000 ->
//    rsp_data == ALU out for the same inputs applied directly.
//  6 rr_ptr=3, only req0 and req3 valid -> req3 granted first, then req0 (wrap-around).

Source files
------------

// File: rtl/fp_alu_scheduler.sv
// Round-robin arbiter sharing one combinational FP ALU between N_REQ requesters.
// Latency: accept edge + ALU_LAT edges to result register; min op period ALU_LAT+2.
// Backpressure: result held on rsp_valid until owner's rsp_ready; req_ready only in IDLE.
module fp_alu_scheduler #(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = 32,
  parameter int SEL_W   = 3,
  parameter int ALU_LAT = 2,
  localparam int IDW    = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  input  logic [N_REQ*SEL_W-1:0] req_sel,
  output logic [WIDTH-1:0]       alu_a,
  output logic [WIDTH-1:0]       alu_b,
  output logic [SEL_W-1:0]       alu_sel,
  input  logic [WIDTH-1:0]       alu_out,
  output logic [N_REQ-1:0]       rsp_valid,
  input  logic [N_REQ-1:0]       rsp_ready,
  output logic [WIDTH-1:0]       rsp_data,
  output logic                   busy,
  output logic [IDW-1:0]         grant_id
);

  localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] win;
  logic           win_vld;
  logic [CW-1:0]  cnt;

  // First valid requester at or above rr_ptr, wrapping.
  always_comb begin : arb
    logic [IDW-1:0] idx;
    idx     = '0;
    win     = '0;
    win_vld = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = IDW'((int'(rr_ptr) + k) % N_REQ);
      if (!win_vld && req_valid[idx]) begin
        win_vld = 1'b1;
        win     = idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    rsp_valid = '0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (win_vld) begin
          req_ready[win] = 1'b1;
          state_nxt      = EXEC;
        end
      end
      EXEC: begin
        if (cnt == '0) state_nxt = RESP;
      end
      RESP: begin
        rsp_valid[grant_id] = 1'b1;
        if (rsp_ready[grant_id]) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr   <= '0;
      cnt      <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_sel  <= '0;
      rsp_data <= '0;
      grant_id <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_vld) begin
            alu_a    <= req_a[int'(win)*WIDTH +: WIDTH];
            alu_b    <= req_b[int'(win)*WIDTH +: WIDTH];
            alu_sel  <= req_sel[int'(win)*SEL_W +: SEL_W];
            grant_id <= win;
            cnt      <= CW'(ALU_LAT - 1);
          end
        end
        EXEC: begin
          // Operands stay put; the ALU result is only trusted once cnt runs out.
          if (cnt != '0) cnt <= cnt - CW'(1);
          else           rsp_data <= alu_out;
        end
        RESP: begin
          if (rsp_ready[grant_id])
            rr_ptr <= (grant_id == IDW'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_alu_scheduler.sv
// Bench for fp_alu_scheduler: directed vector table, multi-cycle corner sequences,
// and randomized traffic checked against a round-robin/latency reference model.
module tb_fp_alu_scheduler;
  localparam int N = 4, W = 32, S = 3, LAT = 2, IDW = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0, req_ready, rsp_valid, rsp_ready = '0;
  logic [N*W-1:0] req_a = '0, req_b = '0;
  logic [N*S-1:0] req_sel = '0;
  logic [W-1:0]   alu_a, alu_b, alu_out, rsp_data;
  logic [S-1:0]   alu_sel;
  logic           busy;
  logic [IDW-1:0] grant_id;
  bit             use_fp = 1'b0;

  int checks = 0, errors = 0;
  int got[8], gcyc[8], ng;

  fp_alu_scheduler #(.N_REQ(N), .WIDTH(W), .SEL_W(S), .ALU_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sel(req_sel), .alu_a(alu_a), .alu_b(alu_b),
    .alu_sel(alu_sel), .alu_out(alu_out), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  function automatic real s2r(input logic [31:0] x);
    logic [63:0] d;
    if (x[30:0] == 31'd0) d = {x[31], 63'd0};
    else d = {x[31], 11'(int'(x[30:23]) + 896), x[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2s(input real r);
    logic [63:0] d;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    return {d[63], 8'(int'(d[62:52]) - 896), d[51:29]};
  endfunction

  // Behavioural single-precision ALU used as the "real" ALU instance.
  function automatic logic [31:0] fpu(input logic [31:0] a, b, input logic [2:0] s);
    real r;
    case (s)
      3'b000:  r = s2r(a) + s2r(b);
      3'b001:  r = s2r(a) - s2r(b);
      3'b100:  r = s2r(a) * s2r(b);
      3'b101:  r = s2r(a) / s2r(b);
      default: r = s2r(a);
    endcase
    return r2s(r);
  endfunction

  always_comb alu_out = use_fp ? fpu(alu_a, alu_b, alu_sel) : alu_a + alu_b;

  function automatic logic [N-1:0] oh(input int i);
    logic [N-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_req(input int i, input logic [31:0] a, b, input logic [2:0] s);
    req_a[i*W +: W]   = a;
    req_b[i*W +: W]   = b;
    req_sel[i*S +: S] = s;
  endtask

  task automatic pulse_reset(input int cyc);
    rst = 1'b1;
    req_valid = '0;
    repeat (cyc) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // One isolated op; entered and left at posedge+1.
  task automatic do_single(input int i, input logic [31:0] a, b, input logic [2:0] s,
                           input logic [31:0] exp);
    int lat;
    set_req(i, a, b, s);
    req_valid = oh(i);
    rsp_ready = '1;
    @(negedge clk);
    chk("single_grant", req_ready, oh(i));
    chk("single_idle", busy, 0);
    @(posedge clk);
    #1 req_valid = '0;
    lat = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (rsp_valid != '0) break;
      lat++;
      chk("hold_a", alu_a, a);
      chk("hold_b", alu_b, b);
      chk("hold_sel", alu_sel, s);
    end
    chk("latency", lat, LAT);
    chk("rsp_valid", rsp_valid, oh(i));
    chk("rsp_data", rsp_data, exp);
    chk("grant_id", grant_id, i);
    chk("hold_a_resp", alu_a, a);
    @(posedge clk);
    @(negedge clk);
    chk("single_done", {busy, rsp_valid}, 0);
    @(posedge clk);
    #1;
  endtask

  // Observe grants; drop a requester's valid once it has been accepted if drop=1.
  task automatic collect(input int ngr, input bit drop);
    bit g;
    ng = 0;
    for (int c = 0; c < 80 && ng < ngr; c++) begin
      @(negedge clk);
      g = 1'b0;
      chk("onehot_ready", 64'($onehot0(req_ready)), 1);
      if (rsp_valid != '0 && ng > 0)
        chk("c_rsp_data", rsp_data, req_a[got[ng-1]*W +: W] + req_b[got[ng-1]*W +: W]);
      if (req_ready != '0) begin
        for (int i = 0; i < N; i++) if (req_ready[i]) got[ng] = i;
        gcyc[ng] = c;
        ng++;
        g = 1'b1;
      end
      @(posedge clk);
      #1 if (drop && g) req_valid[got[ng-1]] = 1'b0;
    end
    chk("grant_count", ng, ngr);
  endtask

  task automatic drain();
    req_valid = '0;
    rsp_ready = '1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk("drain_idle", busy, 0);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int          rq;
    logic [31:0] a, b;
    logic [2:0]  s;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[5];

  // Random-phase model state
  logic [31:0] qa[N][$], qb[N][$];
  logic [2:0]  qs[N][$];
  bit          m_idle;
  int          m_ptr, m_owner, m_cnt, w, done, total, pend;
  logic [31:0] m_a, m_b, m_exp;
  logic [2:0]  m_s;

  initial begin
    tbl[0] = '{0, 32'd5,          32'd7,          3'b010, 32'd12};
    tbl[1] = '{1, 32'hFFFF_FFFF,  32'd2,          3'b111, 32'd1};
    tbl[2] = '{2, 32'd100,        32'd23,         3'b101, 32'd123};
    tbl[3] = '{3, 32'h8000_0000,  32'h8000_0000,  3'b000, 32'd0};
    tbl[4] = '{2, 32'h1234_5678,  32'h1111_1111,  3'b001, 32'h2345_6789};

    // Reset held 3 cycles, then idle outputs all zero
    pulse_reset(3);
    @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_alu", {alu_a, alu_sel}, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_rsp_data", rsp_data, 0);
    @(posedge clk);
    #1;

    for (int t = 0; t < 5; t++) do_single(tbl[t].rq, tbl[t].a, tbl[t].b, tbl[t].s, tbl[t].exp);

    // Last table op came from req2, so rr_ptr=3: req3 must win before req0
    set_req(0, 32'd1, 32'd2, 3'd0);
    set_req(3, 32'd10, 32'd20, 3'd0);
    req_valid = 4'b1001;
    rsp_ready = '1;
    collect(2, 1'b1);
    chk("wrap_first", got[0], 3);
    chk("wrap_second", got[1], 0);
    drain();

    // All four continuously valid after reset: 0,1,2,3,0 at one op per LAT+2 cycles
    pulse_reset(1);
    for (int i = 0; i < N; i++) set_req(i, 32'(i * 16), 32'(i + 1), 3'(i));
    req_valid = '1;
    rsp_ready = '1;
    collect(5, 1'b0);
    for (int k = 0; k < 5; k++) chk("rr_order", got[k], k % N);
    for (int k = 1; k < 5; k++) chk("rr_spacing", gcyc[k] - gcyc[k-1], LAT + 2);
    drain();

    // Response stalled 10 cycles on req1 while others' ready bits are high
    set_req(1, 32'd40, 32'd2, 3'd6);
    set_req(0, 32'd9, 32'd9, 3'd0);
    req_valid = 4'b0010;
    rsp_ready = 4'b1101;
    @(negedge clk);
    chk("stall_grant", req_ready, 4'b0010);
    @(posedge clk);
    #1 req_valid = '0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (rsp_valid != '0) break;
    end
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1 req_valid[0] = 1'b1;
      @(negedge clk);
      chk("stall_rsp_valid", rsp_valid, 4'b0010);
      chk("stall_rsp_data", rsp_data, 32'd42);
      chk("stall_req_ready", req_ready, 0);
      chk("stall_busy", busy, 1);
    end
    @(posedge clk);
    #1 rsp_ready = '1;
    @(negedge clk);
    chk("stall_still_resp", rsp_valid, 4'b0010);
    @(posedge clk);
    @(negedge clk);
    chk("stall_done", busy, 0);
    chk("stall_next_winner", req_ready, 4'b0001);
    req_valid = '0;
    @(posedge clk);
    #1;

    // Reset mid-EXEC: op dropped, no response, rr_ptr back to 0
    set_req(3, 32'd77, 32'd1, 3'd2);
    req_valid = 4'b1000;
    @(negedge clk);
    chk("x_grant", req_ready, 4'b1000);
    @(posedge clk);
    #1 req_valid = '0;
    @(negedge clk);
    chk("x_exec_busy", busy, 1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("x_busy", busy, 0);
    chk("x_alu_a", alu_a, 0);
    chk("x_grant_id", grant_id, 0);
    for (int c = 0; c < 5; c++) begin
      chk("x_no_rsp", rsp_valid, 0);
      @(negedge clk);
    end
    req_valid = 4'b1010;
    #1 chk("x_rr_ptr0", req_ready, 4'b0010);
    req_valid = '0;
    @(posedge clk);
    #1;

    // Real FP ALU behind the scheduler
    use_fp = 1'b1;
    do_single(0, 32'h4140_0000, 32'h4080_0000, 3'b101, fpu(32'h4140_0000, 32'h4080_0000, 3'b101));
    use_fp = 1'b0;

    // Randomized traffic against round-robin/latency model
    pulse_reset(2);
    total = 0;
    for (int i = 0; i < N; i++) begin
      int n;
      n = int'($urandom_range(12, 4));
      for (int k = 0; k < n; k++) begin
        qa[i].push_back($urandom);
        qb[i].push_back($urandom);
        qs[i].push_back(3'($urandom));
      end
      total += n;
    end
    m_idle = 1'b1; m_ptr = 0; m_owner = 0; m_cnt = 0; done = 0;
    m_a = '0; m_b = '0; m_s = '0; m_exp = '0;
    for (int cyc = 0; cyc < 5000; cyc++) begin
      pend = 0;
      for (int i = 0; i < N; i++) begin
        pend += qa[i].size();
        if (qa[i].size() > 0) begin
          set_req(i, qa[i][0], qb[i][0], qs[i][0]);
          req_valid[i] = ($urandom_range(3) != 0);
        end else req_valid[i] = 1'b0;
      end
      rsp_ready = 4'($urandom);
      if (pend == 0 && m_idle) break;
      @(negedge clk);
      if (m_idle) begin
        w = -1;
        for (int k = 0; k < N; k++)
          if (w < 0 && req_valid[(m_ptr + k) % N]) w = (m_ptr + k) % N;
        chk("rnd_req_ready", req_ready, (w < 0) ? '0 : oh(w));
        chk("rnd_idle_busy", busy, 0);
        if (w >= 0) begin
          m_owner = w; m_a = qa[w][0]; m_b = qb[w][0]; m_s = qs[w][0];
          m_exp = m_a + m_b;
          void'(qa[w].pop_front()); void'(qb[w].pop_front()); void'(qs[w].pop_front());
          m_idle = 1'b0; m_cnt = 0;
        end
      end else begin
        chk("rnd_busy", busy, 1);
        chk("rnd_no_ready", req_ready, 0);
        chk("rnd_hold", {alu_a, alu_b, alu_sel}, {m_a, m_b, m_s});
        if (m_cnt >= LAT) begin
          chk("rnd_rsp_valid", rsp_valid, oh(m_owner));
          chk("rnd_rsp_data", rsp_data, m_exp);
          chk("rnd_grant_id", grant_id, m_owner);
          if (rsp_ready[m_owner]) begin
            m_idle = 1'b1;
            m_ptr = (m_owner + 1) % N;
            done++;
          end
        end else begin
          chk("rnd_rsp_early", rsp_valid, 0);
          m_cnt++;
        end
      end
      @(posedge clk);
      #1;
    end
    chk("rnd_all_done", done, total);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
